// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - default word-address and instruction-word widths
//   - loader FSM state encoding
//   - bytes-per-word helper and the stream byte-order constant
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int ADDR_W_DEF = 30;  // PC[31:2] word-address path
  localparam int DATA_W_DEF = 32;  // instruction word width

  // Stream byte order: the first byte of each word lands in the top byte.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Width of a counter that indexes bytes within one word (at least 1 bit).
  function automatic int byte_cnt_w(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_packer (module byte_packer)
// Assembles a stream of bytes into one instruction word.
//   clk, reset_n : clock, asynchronous active-low reset
//   byte_en      : a byte transfers this cycle
//   byte_data    : the transferring byte
//   word_next    : the word formed by the stored bytes plus byte_data
//   word_ready   : byte_en is set and byte_data completes the word
// Only the first BYTES-1 bytes are stored; the final byte is merged
// combinationally so the word can be captured on the same edge it arrives.
// ---------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word_next,
  output logic              word_ready
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int CNT_W = byte_cnt_w(DATA_W);

  logic [CNT_W-1:0] byte_cnt;
  logic             last_byte;

  assign last_byte  = (byte_cnt == CNT_W'(BYTES - 1));
  assign word_ready = byte_en && last_byte;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
    end else if (byte_en) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
    end
  end

  generate
    if (BYTES == 1) begin : g_single
      assign word_next = byte_data;
    end else begin : g_multi
      logic [DATA_W-9:0] shift;

      if (MSB_FIRST) begin : g_msb
        assign word_next = {shift, byte_data};
      end else begin : g_lsb
        assign word_next = {byte_data, shift};
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shift <= '0;
        end else if (byte_en) begin
          shift <= MSB_FIRST ? word_next[DATA_W-9:0] : word_next[DATA_W-1:8];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction-memory interface. Takes a big-endian byte
// stream, builds DATA_W-bit words and writes them to consecutive word
// addresses, holding the fetch stage for the whole load.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start                   : load request, honoured only in IDLE
//   base_addr, word_count   : first word address / number of words
//   byte_valid, byte_data   : byte stream in, MSB of each word first
//   byte_ready              : loader accepts a byte this cycle (LOAD only)
//   imem_we/addr/wdata      : instruction-memory write port
//   fetch_hold, busy        : high from LOAD through DONE
//   done                    : one-cycle completion pulse
// Every output is a flop; nothing combinational reaches them from byte_valid.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              fetch_hold,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic              byte_en;
  logic [DATA_W-1:0] word_next;
  logic              word_ready;

  // byte_ready is only high in LOAD, so this also gates out bytes offered
  // in IDLE, WRITE and DONE; the source must keep holding them.
  assign byte_en = byte_valid && byte_ready;

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Outputs are registered next to the state so each one reflects the state
  // it belongs to; reset clears them asynchronously, aborting any load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      fetch_hold <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes default low; imem_addr/imem_wdata keep their last value.
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            remain_q   <= word_count;
            busy       <= 1'b1;
            fetch_hold <= 1'b1;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              byte_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (word_ready) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= addr_q;
            imem_wdata <= word_next;
          end
        end
        ST_WRITE: begin
          // Address wraps silently at the top of the word space.
          addr_q   <= addr_q + ADDR_W'(1);
          remain_q <= remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state      <= ST_LOAD;
            byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          fetch_hold <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: a table of load records (base, count,
// stall pattern, words) is replayed in a loop, followed by hand-written
// sequences for start-while-busy and reset in the middle of a word.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              fetch_hold;
  logic              busy;
  logic              done;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .fetch_hold (fetch_hold),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] count;
    bit                stall;
    logic [3:0][31:0]  w;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Write/done monitor
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  int                done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      check("byte_ready_low_in_write", {63'd0, byte_ready}, 64'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Offer one byte at a falling edge and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'hFF;
  endtask

  task automatic run_load(input vec_t v);
    int                w0;
    int                d0;
    logic [ADDR_W-1:0] ea;
    w0 = wr_addr_q.size();
    d0 = done_cnt;
    base_addr  = v.base;
    word_count = v.count;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.name, ":fetch_hold_after_start"}, {63'd0, fetch_hold}, 64'd1);
    if (v.count == '0) begin
      check({v.name, ":done_direct"}, {63'd0, done}, 64'd1);
      check({v.name, ":byte_ready_zero"}, {63'd0, byte_ready}, 64'd0);
    end else begin
      for (int i = 0; i < int'(v.count); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (v.stall) @(negedge clk);
          send_byte(v.w[i][31-8*b -: 8]);
        end
      end
      // One cycle after the last byte: the write, then done.
      check({v.name, ":we_latency"}, {63'd0, imem_we}, 64'd1);
      @(negedge clk);
      check({v.name, ":done_pulse"}, {63'd0, done}, 64'd1);
      check({v.name, ":hold_in_done"}, {62'd0, busy, fetch_hold}, 64'd3);
    end
    @(negedge clk);
    check({v.name, ":idle_after"}, {61'd0, done, busy, fetch_hold}, 64'd0);
    check({v.name, ":write_count"}, 64'(wr_addr_q.size() - w0), 64'(v.count));
    for (int i = 0; i < int'(v.count) && (w0 + i) < wr_addr_q.size(); i++) begin
      ea = v.base + ADDR_W'(i);
      check({v.name, ":addr"}, 64'(wr_addr_q[w0+i]), 64'(ea));
      check({v.name, ":data"}, 64'(wr_data_q[w0+i]), 64'(v.w[i]));
    end
    check({v.name, ":done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  vec_t vecs[5];
  vec_t v;
  int   w0;

  initial begin
    vecs[0] = '{"single",   30'h10,       30'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h8C010004}};
    vecs[1] = '{"stall3",   30'h0,        30'd3, 1'b1, {32'h0, 32'h99AABBCC, 32'h55667788, 32'h11223344}};
    vecs[2] = '{"zero",     30'h0,        30'd0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{"wrap",     30'h3FFFFFFF, 30'd2, 1'b0, {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF}};
    vecs[4] = '{"four",     30'h100,      30'd4, 1'b0, {32'hCAFEF00D, 32'h0F0F0F0F, 32'h80000001, 32'h00000000}};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(negedge clk);
    check("reset_outputs", {58'd0, byte_ready, imem_we, fetch_hold, busy, done, 1'b0}, 64'd0);
    check("reset_addr_data", {2'd0, imem_addr, imem_wdata}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) run_load(vecs[k]);

    // start pulsed during LOAD must be ignored.
    v = '{"busy_start", 30'h20, 30'd2, 1'b0, {32'h0, 32'h0, 32'hA5A55A5A, 32'h13579BDF}};
    fork
      run_load(v);
      begin
        repeat (3) @(negedge clk);
        base_addr  = 30'h55;
        word_count = 30'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("busy_start:stays_idle", {62'd0, busy, imem_we}, 64'd0);

    // Reset after 2 of 4 bytes: no write, outputs cleared at once.
    base_addr  = 30'h40;
    word_count = 30'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    w0 = wr_addr_q.size();
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {59'd0, byte_ready, imem_we, fetch_hold, busy, done}, 64'd0);
    check("midreset_addr_data", {2'd0, imem_addr, imem_wdata}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_write", 64'(wr_addr_q.size() - w0), 64'd0);
    v = '{"after_reset", 30'h7, 30'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}};
    run_load(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
